sudoku_solve_ctrl: RTL and testbench

Sequencer for the 9x9 constraint-propagation solver. It accepts a puzzle as an 81-beat cell stream, writes each cell into the solver's initial-value buffer and pulses the solver's start. It then monitors resolution progress and classifies the outcome as solved, contradiction, stall or timeout. Finally it streams the 81 result digits back with the outcome status. It replaces the separate input/output transfer FSMs and row/column counters at the top level.

---
 rtl/sudoku_solve_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sudoku_solve_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_solve_ctrl.sv
// sudoku_solve_ctrl: top-level sequencer for the 9x9 constraint-propagation
// solver. Streams a puzzle into the initial-value buffer, starts the solver,
// classifies the outcome and streams the 81 result digits back with status.
module sudoku_solve_ctrl #(
  parameter int STALL_CYCLES = 8,
  parameter int MAX_CYCLES   = 1024
) (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        cell_we,
  output logic [3:0]  cell_row,
  output logic [3:0]  cell_col,
  output logic [3:0]  cell_digit,
  output logic        solver_start,
  input  logic [80:0] solver_resolved,
  input  logic        solver_fail,
  output logic [3:0]  rd_row,
  output logic [3:0]  rd_col,
  input  logic [3:0]  rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy
);

  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_CYCLES - 1);
  localparam logic [CW-1:0] CYC_LAST   = CW'(MAX_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_SOLVE  = 3'd3;
  localparam logic [2:0] S_UNLOAD = 3'd4;

  localparam logic [1:0] ST_SOLVED  = 2'd0;
  localparam logic [1:0] ST_CONTRA  = 2'd1;
  localparam logic [1:0] ST_STALL   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  logic [2:0]    state;
  logic [3:0]    in_row, in_col;
  logic [3:0]    out_row, out_col;
  logic [6:0]    prev_cnt;
  logic [6:0]    cnt;
  logic [SW-1:0] stall_cnt;
  logic [CW-1:0] cyc;
  logic [1:0]    status;
  logic          in_last;
  logic          out_fire;
  logic          unused_in_bits;

  // Upper input bits carry nothing for this block.
  assign unused_in_bits = ^in_data[31:4];

  // Resolved-cell count of the current solver state.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    cnt = '0;
    for (int i = 0; i < 81; i++) cnt = cnt + 7'(solver_resolved[i]);
  end

  assign in_ready     = (state == S_IDLE) || (state == S_LOAD);
  assign cell_we      = in_valid && in_ready;
  assign cell_row     = in_row;
  assign cell_col     = in_col;
  assign cell_digit   = (in_data[3:0] > 4'd9) ? 4'd0 : in_data[3:0];
  assign in_last      = (in_row == 4'd8) && (in_col == 4'd8);

  assign solver_start = (state == S_START);
  assign busy         = (state != S_IDLE);

  assign out_valid    = (state == S_UNLOAD);
  assign rd_row       = out_row;
  assign rd_col       = out_col;
  assign out_data     = {26'd0, status, rd_data};
  assign out_last     = out_valid && (out_row == 4'd8) && (out_col == 4'd8);
  assign out_fire     = out_valid && out_ready;

  // Sequencer state, transfer counters and progress monitoring.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state     <= S_IDLE;
      in_row    <= '0;
      in_col    <= '0;
      out_row   <= '0;
      out_col   <= '0;
      prev_cnt  <= '0;
      stall_cnt <= '0;
      cyc       <= '0;
      status    <= ST_SOLVED;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      case (state)
        S_IDLE, S_LOAD: begin
          if (cell_we) begin
            if (in_last) begin
              in_row <= '0;
              in_col <= '0;
              state  <= S_START;
            end else begin
              state <= S_LOAD;
              if (in_col == 4'd8) begin
                in_col <= '0;
                in_row <= in_row + 4'd1;
              end else begin
                in_col <= in_col + 4'd1;
              end
            end
          end
        end
        S_START: begin
          prev_cnt  <= '0;
          stall_cnt <= '0;
          cyc       <= '0;
          state     <= S_SOLVE;
        end
        S_SOLVE: begin
          stall_cnt <= (cnt != prev_cnt) ? '0 : stall_cnt + SW'(1);
          prev_cnt  <= cnt;
          cyc       <= cyc + CW'(1);
          if (solver_fail) begin
            status <= ST_CONTRA;
            state  <= S_UNLOAD;
          end else if (cnt == 7'd81) begin
            status <= ST_SOLVED;
            state  <= S_UNLOAD;
          end else if ((cnt == prev_cnt) && (stall_cnt == STALL_LAST)) begin
            status <= ST_STALL;
            state  <= S_UNLOAD;
          end else if (cyc == CYC_LAST) begin
            status <= ST_TIMEOUT;
            state  <= S_UNLOAD;
          end
        end
        S_UNLOAD: begin
          if (out_fire) begin
            if (out_last) begin
              out_row <= '0;
              out_col <= '0;
              state   <= S_IDLE;
            end else if (out_col == 4'd8) begin
              out_col <= '0;
              out_row <= out_row + 4'd1;
            end else begin
              out_col <= out_col + 4'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sudoku_solve_ctrl.sv
// tb_sudoku_solve_ctrl: directed bench with a small solver model and a
// table of end-to-end scenarios, plus reset-abort sequences.
module tb_sudoku_solve_ctrl;

  logic        clk = 1'b0;
  logic        reset_L;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        cell_we;
  logic [3:0]  cell_row, cell_col, cell_digit;
  logic        solver_start;
  logic [80:0] solver_resolved;
  logic        solver_fail;
  logic [3:0]  rd_row, rd_col, rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int mode  = 0;
  int scyc  = 1000;

  typedef struct {
    int         mode;
    logic [1:0] status;
    int         lat;
    bit         gaps;
    bit         bp;
  } vec_t;

  vec_t vecs [4];

  sudoku_solve_ctrl #(.STALL_CYCLES(8), .MAX_CYCLES(64)) dut (
    .clk(clk), .reset_L(reset_L),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cell_we(cell_we), .cell_row(cell_row), .cell_col(cell_col), .cell_digit(cell_digit),
    .solver_start(solver_start), .solver_resolved(solver_resolved), .solver_fail(solver_fail),
    .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [80:0] mask(input int n);
    logic [80:0] m;
    for (int i = 0; i < 81; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic logic [3:0] digit_at(input int r, input int c);
    return 4'((r + 2 * c) % 10);
  endfunction

  // Solver model: cycles counted from the start pulse, SOLVE cycle k <=> scyc == k.
  always @(posedge clk) begin
    if (solver_start) scyc <= 0;
    else              scyc <= scyc + 1;
  end

  always_comb begin
    solver_fail     = 1'b0;
    solver_resolved = '0;
    case (mode)
      0: solver_resolved = mask(81);
      1: solver_resolved = mask(40);
      2: begin
        if (scyc < 3) solver_resolved = mask(scyc + 1);
        else begin
          solver_resolved = mask(81);
          solver_fail     = 1'b1;
        end
      end
      3: solver_resolved = mask(scyc / 8 + 1);
      default: solver_resolved = '0;
    endcase
  end

  assign rd_data = digit_at(int'(rd_row), int'(rd_col));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks();
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_start", solver_start, 0);
    check("rst_cell_we", cell_we, 0);
  endtask

  task automatic load_puzzle(input bit gaps);
    int i = 0;
    int dig;
    while (i < 81) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        in_data  = $urandom;
        #1;
        check("we_gap", cell_we, 0);
      end else begin
        dig      = (i == 9) ? 12 : (i % 10);
        in_valid = 1'b1;
        in_data  = {28'($urandom), 4'(dig)};
        #1;
        check("in_ready", in_ready, 1);
        check("cell_we", cell_we, 1);
        check("cell_row", cell_row, i / 9);
        check("cell_col", cell_col, i % 9);
        check("cell_digit", cell_digit, (dig > 9) ? 0 : dig);
        i++;
      end
    end
    // START cycle: single pulse, input side closed.
    @(negedge clk);
    in_valid = 1'b1;
    #1;
    check("start_pulse", solver_start, 1);
    check("start_in_ready", in_ready, 0);
    check("start_cell_we", cell_we, 0);
    check("start_busy", busy, 1);
  endtask

  task automatic wait_unload(input int exp_lat);
    bit got = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = $urandom;
      out_ready = 1'b0;
      #1;
      if (out_valid) begin
        got = 1;
        break;
      end
      check("solve_cell_we", cell_we, 0);
      check("solve_in_ready", in_ready, 0);
      check("solve_start_once", solver_start, 0);
    end
    in_valid = 1'b0;
    check("unload_reached", got, 1);
    if (got) check("exit_latency", scyc, exp_lat);
  endtask

  // Continues in the current cycle (first UNLOAD cycle already sampled).
  task automatic unload(input logic [1:0] st, input bit bp, input int abort_at);
    int  i = 0;
    int  k = 0;
    bit  first = 1;
    while (i < 81 && k < 2000) begin
      if (!first) @(negedge clk);
      first = 0;
      k++;
      if (i == abort_at) begin
        reset_L   = 1'b0;
        out_ready = 1'b0;
        #1;
        reset_checks();
        @(negedge clk);
        reset_L = 1'b1;
        #1;
        check("abort_idle", busy, 0);
        check("abort_no_beat", out_valid, 0);
        return;
      end
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      check("out_valid", out_valid, 1);
      check("out_data", out_data, {26'd0, st, digit_at(i / 9, i % 9)});
      check("out_last", out_last, (i == 80) ? 1 : 0);
      if (out_ready) i++;
    end
    check("unload_done", i, 81);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    check("end_out_valid", out_valid, 0);
    check("end_busy", busy, 0);
    check("end_in_ready", in_ready, 1);
  endtask

  task automatic run_vec(input vec_t v);
    mode = v.mode;
    load_puzzle(v.gaps);
    wait_unload(v.lat);
    unload(v.status, v.bp, -1);
  endtask

  initial begin
    vecs[0] = '{mode: 0, status: 2'd0, lat: 1,  gaps: 1'b0, bp: 1'b0};  // complete grid
    vecs[1] = '{mode: 1, status: 2'd2, lat: 9,  gaps: 1'b1, bp: 1'b0};  // stall, input gaps
    vecs[2] = '{mode: 2, status: 2'd1, lat: 4,  gaps: 1'b0, bp: 1'b1};  // contradiction, backpressure
    vecs[3] = '{mode: 3, status: 2'd3, lat: 64, gaps: 1'b0, bp: 1'b0};  // timeout

    reset_L   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    reset_L = 1'b1;

    for (int v = 0; v < 4; v++) run_vec(vecs[v]);

    // Reset in the middle of SOLVE.
    mode = 1;
    load_puzzle(1'b0);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset_L = 1'b0;
    #1;
    reset_checks();
    @(negedge clk);
    reset_L = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      check("post_rst_idle", busy, 0);
      check("post_rst_no_beat", out_valid, 0);
    end
    run_vec(vecs[0]);

    // Reset at output beat 40, then puzzles still complete normally.
    mode = 1;
    load_puzzle(1'b0);
    wait_unload(9);
    unload(2'd2, 1'b0, 40);
    run_vec(vecs[2]);
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
